demux_route_sequencer: RTL and testbench

- Upstream control stage for the 8-bit 1-to-3 demultiplexer.
- Accepts a byte stream on a valid/ready handshake and holds each byte in a one-entry register.
- Drives the demux data and select lines.
- Steers bursts of BURST bytes to destination 1, 2, 3 in round-robin order. It waits on each destination's ready and pulses a one-hot write strobe when a transfer completes.

---
 rtl/demux_route_sequencer_pkg.sv | 33 +++
 rtl/demux_burst_counter.sv | 56 +++++
 rtl/demux_route_sequencer.sv | 81 ++++++++
 tb/tb_demux_route_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_route_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_route_sequencer_pkg
//  Purpose  : Shared definitions for the demux route sequencer, its burst
//             counter and the integrating demux wrapper/benches.
//  Contents : demux select encodings, handshake FSM state type,
//             destination count, counter width helper.
//  Revision : 1.0  initial release
// ============================================================================
package demux_route_sequencer_pkg;

  // Number of demux destinations.
  localparam int NUM_DST = 3;

  // Demux select encodings; SEL_PARK drives all demux outputs to zero.
  localparam logic [1:0] SEL_OUT1 = 2'd0;
  localparam logic [1:0] SEL_OUT2 = 2'd1;
  localparam logic [1:0] SEL_OUT3 = 2'd2;
  localparam logic [1:0] SEL_PARK = 2'd3;

  // Handshake FSM states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Width of the in-burst counter; at least one bit even for BURST=1.
  function automatic int cnt_width(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage : demux_route_sequencer_pkg
`default_nettype wire

// File: rtl/demux_burst_counter.sv
`default_nettype none
// ============================================================================
//  Module   : demux_burst_counter
//  Purpose  : Round-robin destination pointer. Counts completed transfers
//             and rotates the pointer 0->1->2->0 after every BURST of them.
//  Ports    : clk        system clock
//             reset      synchronous active-high reset (ptr=0, cnt=0)
//             advance_i  a transfer completed this cycle
//             ptr_o      current destination index (0..2, never 3)
//  Revision : 1.0  initial release
// ============================================================================
module demux_burst_counter
  import demux_route_sequencer_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance_i,
  output logic [1:0] ptr_o
);

  localparam int                CNT_W    = cnt_width(BURST);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST - 1);

  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (advance_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        // Explicit wrap keeps the pointer out of the park encoding.
        ptr_d = (ptr_q == SEL_OUT3) ? SEL_OUT1 : ptr_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= SEL_OUT1;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : demux_burst_counter
`default_nettype wire

// File: rtl/demux_route_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : demux_route_sequencer
//  Purpose  : Upstream control for the 8-bit 1-to-3 demux. Holds one byte
//             from a valid/ready stream, drives the demux data/select lines
//             and pulses a one-hot write strobe when the selected
//             destination is ready. Bursts of BURST bytes rotate 1->2->3.
//  Ports    : clk, reset      clock, synchronous active-high reset
//             in_data/valid   upstream byte and its valid
//             in_ready        byte can be accepted this cycle
//             dst_ready[2:0]  per-destination ready (bit k = dest k+1)
//             demux_a         demux data input (held byte)
//             demux_sel       demux select, 3 = parked
//             dst_we[2:0]     one-hot destination write strobe
//             busy            a byte is held and not yet delivered
//  Revision : 1.0  initial release
// ============================================================================
module demux_route_sequencer
  import demux_route_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_DST-1:0] dst_ready,
  output logic [WIDTH-1:0]   demux_a,
  output logic [1:0]         demux_sel,
  output logic [NUM_DST-1:0] dst_we,
  output logic               busy
);

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       ptr;
  logic             sending;
  logic             xfer;
  logic             acc;

  demux_burst_counter #(
    .BURST (BURST)
  ) u_burst_counter (
    .clk       (clk),
    .reset     (reset),
    .advance_i (xfer),
    .ptr_o     (ptr)
  );

  assign sending   = (state_q == ST_SEND);
  // Only the selected destination's ready matters; others are ignored.
  assign xfer      = sending & dst_ready[ptr];
  assign acc       = in_valid & in_ready;

  assign demux_a   = data_q;
  assign demux_sel = sending ? ptr : SEL_PARK;
  assign dst_we    = xfer ? (3'b001 << ptr) : 3'b000;
  // Accepting while delivering gives one byte per cycle back-to-back.
  assign in_ready  = ~sending | xfer;
  assign busy      = sending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
    end else begin
      if (acc) begin
        data_q <= in_data;
      end
      case (state_q)
        ST_IDLE: if (acc) state_q <= ST_SEND;
        ST_SEND: if (xfer && !acc) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule : demux_route_sequencer
`default_nettype wire

// File: tb/tb_demux_route_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_route_sequencer
//  Purpose  : Self-checking bench. Three instances (BURST = 4, 2, 1) share
//             the same stimulus; a transfer-count model predicts every
//             output each cycle, and directed sections pin literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_route_sequencer;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [2:0] dst_ready = 3'b000;

  logic       rdy_o  [N];
  logic [7:0] a_o    [N];
  logic [1:0] sel_o  [N];
  logic [2:0] we_o   [N];
  logic       busy_o [N];

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  function automatic int bl(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 2 : 1);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    demux_route_sequencer #(
      .WIDTH (8),
      .BURST ((g == 0) ? 4 : ((g == 1) ? 2 : 1))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (rdy_o[g]),
      .dst_ready (dst_ready),
      .demux_a   (a_o[g]),
      .demux_sel (sel_o[g]),
      .dst_we    (we_o[g]),
      .busy      (busy_o[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a held byte, its value, and the total number of completed
  // transfers since reset; the destination is (transfers / BURST) mod 3.
  bit         m_held [N];
  logic [7:0] m_data [N];
  int         m_xcnt [N];

  initial begin
    for (int g = 0; g < N; g++) begin
      m_held[g] = 1'b0;
      m_data[g] = 8'h00;
      m_xcnt[g] = 0;
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      int p;
      bit xf, rd;
      p  = (m_xcnt[g] / bl(g)) % 3;
      xf = m_held[g] && dst_ready[p];
      rd = !m_held[g] || xf;
      if (reset) begin
        m_held[g] = 1'b0;
        m_data[g] = 8'h00;
        m_xcnt[g] = 0;
      end else begin
        if (xf) m_xcnt[g] = m_xcnt[g] + 1;
        if (in_valid && rd) begin
          m_data[g] = in_data;
          m_held[g] = 1'b1;
        end else if (xf) begin
          m_held[g] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int g = 0; g < N; g++) begin
        int p;
        bit xf;
        p  = (m_xcnt[g] / bl(g)) % 3;
        xf = m_held[g] && dst_ready[p];
        chk($sformatf("model.sel[%0d]", g),  32'(sel_o[g]),  m_held[g] ? 32'(p) : 32'd3);
        chk($sformatf("model.a[%0d]", g),    32'(a_o[g]),    32'(m_data[g]));
        chk($sformatf("model.we[%0d]", g),   32'(we_o[g]),   xf ? (32'd1 << p) : 32'd0);
        chk($sformatf("model.rdy[%0d]", g),  32'(rdy_o[g]),  32'(!m_held[g] || xf));
        chk($sformatf("model.busy[%0d]", g), 32'(busy_o[g]), 32'(m_held[g]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
  endtask

  initial begin
    logic [2:0] we_exp2 [6];
    logic [2:0] we_exp1 [4];
    logic [1:0] sel_exp1 [4];
    we_exp2  = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    we_exp1  = '{3'b001, 3'b010, 3'b100, 3'b001};
    sel_exp1 = '{2'd0, 2'd1, 2'd2, 2'd0};

    // Reset with in_valid asserted for two cycles.
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h55; dst_ready = 3'b111;
    tick();
    check_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst.sel",  32'(sel_o[0]),  32'd3);
      chk("rst.we",   32'(we_o[0]),   32'd0);
      chk("rst.rdy",  32'(rdy_o[0]),  32'd1);
      chk("rst.busy", 32'(busy_o[0]), 32'd0);
      chk("rst.a",    32'(a_o[0]),    32'd0);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("idle.we", 32'(we_o[0]), 32'd0);

    // Streaming 0x11..0x16 back-to-back into the BURST=2 instance.
    do_reset();
    dst_ready = 3'b111;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stream.we",  32'(we_o[1]),  32'(we_exp2[i]));
      chk("stream.a",   32'(a_o[1]),   32'(8'h11 + i));
      chk("stream.rdy", 32'(rdy_o[1]), 32'd1);
      if (i < 5) in_data = 8'(8'h12 + i);
      else       in_valid = 1'b0;
      tick();
    end
    @(negedge clk);
    chk("stream.end.busy", 32'(busy_o[1]), 32'd0);

    // Back-pressure on destination 1.
    do_reset();
    dst_ready = 3'b000;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    tick();
    in_valid  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp.sel",  32'(sel_o[0]),  32'd0);
      chk("bp.a",    32'(a_o[0]),    32'hA5);
      chk("bp.rdy",  32'(rdy_o[0]),  32'd0);
      chk("bp.busy", 32'(busy_o[0]), 32'd1);
      tick();
    end
    dst_ready = 3'b001;
    @(negedge clk);
    chk("bp.we", 32'(we_o[0]), 32'b001);
    tick();
    @(negedge clk);
    chk("bp.idle", 32'(busy_o[0]), 32'd0);
    chk("bp.we0",  32'(we_o[0]),   32'd0);

    // Wrong-destination ready on the BURST=1 instance (ptr=1).
    do_reset();
    dst_ready = 3'b111;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    tick();
    @(negedge clk);
    dst_ready = 3'b101;
    in_data   = 8'h77;
    tick();
    in_valid  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("wd.we",   32'(we_o[2]),   32'd0);
      chk("wd.busy", 32'(busy_o[2]), 32'd1);
      chk("wd.sel",  32'(sel_o[2]),  32'd1);
      chk("wd.a",    32'(a_o[2]),    32'h77);
      tick();
    end
    dst_ready = 3'b010;
    @(negedge clk);
    chk("wd.we1", 32'(we_o[2]), 32'b010);
    tick();

    // Wrap-around with BURST=1.
    do_reset();
    dst_ready = 3'b111;
    in_valid  = 1'b1;
    in_data   = 8'hC0;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap.we",  32'(we_o[2]),  32'(we_exp1[i]));
      chk("wrap.sel", 32'(sel_o[2]), 32'(sel_exp1[i]));
      if (i < 3) in_data = 8'(8'hC1 + i);
      else       in_valid = 1'b0;
      tick();
    end

    // Reset mid-operation discards the held byte.
    do_reset();
    dst_ready = 3'b000;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    tick();
    in_valid  = 1'b0;
    @(negedge clk);
    chk("mr.hold", 32'(a_o[0]), 32'h3C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dst_ready = 3'b111;
    @(negedge clk);
    chk("mr.sel",  32'(sel_o[0]),  32'd3);
    chk("mr.busy", 32'(busy_o[0]), 32'd0);
    chk("mr.a",    32'(a_o[0]),    32'd0);
    chk("mr.we",   32'(we_o[0]),   32'd0);
    in_valid = 1'b1;
    in_data  = 8'h42;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mr.ptr0", 32'(we_o[0]), 32'b001);
    tick();

    // Randomized traffic, back-pressure and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      dst_ready = 3'($urandom);
      if ($urandom_range(0, 3) == 0) dst_ready = 3'b000;
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_demux_route_sequencer
`default_nettype wire
